// File: rtl/rr_scope_pkg.sv
// Shared types and helpers for the round-robin scope arbiter.
package rr_scope_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned REQ_MIN = 32'd2;
    localparam int unsigned REQ_MAX = 32'd16;

    // True when the requester count is in range and the index tag can encode every requester.
    function automatic logic cfg_ok(input int unsigned num_req, input int unsigned idx_width);
        return (num_req >= REQ_MIN) && (num_req <= REQ_MAX) &&
               ((32'd1 << idx_width) >= num_req);
    endfunction

    // Modulo-n increment; wraps on an explicit compare so non-power-of-two counts work.
    function automatic logic [31:0] idx_inc(input logic [31:0] idx, input logic [31:0] n);
        logic [31:0] nxt;
        if (idx == (n - 32'd1)) begin
            nxt = 32'd0;
        end else begin
            nxt = idx + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_scope_arbiter_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ   = 5,
    parameter int IDX_WIDTH = 3
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_WIDTH:0]   w_sum;
    logic [IDX_WIDTH-1:0] w_idx;

    // Rotating the doubled vector right by ptr puts the highest-priority requester at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NUM_REQ'(w_dbl >> i_ptr);
    assign o_any = |i_req;

    // Lowest set bit of the rotated vector, mapped back to an absolute requester index.
    always_comb begin
        w_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = w_rot[k] ? ({1'b0, i_ptr} + (IDX_WIDTH+1)'(k)) : w_sum;
        end
        if (w_sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
            w_idx = IDX_WIDTH'(w_sum - (IDX_WIDTH+1)'(NUM_REQ));
        end else begin
            w_idx = w_sum[IDX_WIDTH-1:0];
        end
    end

    // One-hot decode of the picked index, empty when nobody requests.
    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            o_grant[j] = o_any & (w_idx == IDX_WIDTH'(j));
        end
    end

    assign o_idx = w_idx;

endmodule

// File: rtl/rr_scope_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot among NUM_REQ requesters.
module rr_scope_arbiter
    import rr_scope_pkg::*;
#(
    parameter int NUM_REQ    = 5,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_WIDTH-1:0]          out_idx,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          busy
);

    if (!cfg_ok(NUM_REQ, IDX_WIDTH)) begin : g_cfg_err
        $error("rr_scope_arbiter: NUM_REQ must be 2..16 and fit in IDX_WIDTH bits");
    end

    state_e                r_state;
    state_e                w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic [IDX_WIDTH-1:0]  w_ptr_nxt;
    logic                  r_out_valid;
    logic                  w_out_valid_nxt;
    logic [IDX_WIDTH-1:0]  r_out_idx;
    logic [IDX_WIDTH-1:0]  w_out_idx_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;

    logic [NUM_REQ-1:0]    w_grant;
    logic [NUM_REQ-1:0]    w_req_ready;
    logic [IDX_WIDTH-1:0]  w_pick_idx;
    logic [DATA_WIDTH-1:0] w_pick_data;
    logic                  w_any;
    logic                  w_slot_free;
    logic                  w_accept;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // AND-OR mux of the granted requester's word.
    always_comb begin
        w_pick_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_pick_data = w_pick_data |
                (req_data[j*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[j]}});
        end
    end

    // Grants are suppressed while in reset so no requester sees a phantom accept.
    assign w_slot_free = (r_state == ST_EMPTY) | (out_ready & r_out_valid);
    assign w_req_ready = (rst_n & w_slot_free & w_any) ? w_grant : '0;
    assign w_accept    = |(req_valid & w_req_ready);

    // Next-state and slot-load logic; a drain and accept in one cycle simply reloads the slot.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_out_valid_nxt = r_out_valid;
        w_out_idx_nxt   = r_out_idx;
        w_out_data_nxt  = r_out_data;
        if (w_accept) begin
            w_ptr_nxt = IDX_WIDTH'(idx_inc(32'(w_pick_idx), 32'(NUM_REQ)));
        end else begin
            w_ptr_nxt = r_ptr;
        end
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt     = ST_FULL;
                    w_out_valid_nxt = 1'b1;
                    w_out_idx_nxt   = w_pick_idx;
                    w_out_data_nxt  = w_pick_data;
                end else begin
                    w_state_nxt     = ST_EMPTY;
                    w_out_valid_nxt = 1'b0;
                end
            end
            ST_FULL: begin
                if (w_accept) begin
                    w_state_nxt     = ST_FULL;
                    w_out_valid_nxt = 1'b1;
                    w_out_idx_nxt   = w_pick_idx;
                    w_out_data_nxt  = w_pick_data;
                end else if (out_ready) begin
                    w_state_nxt     = ST_EMPTY;
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt     = ST_FULL;
                    w_out_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_EMPTY;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer and output slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign req_ready = w_req_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign busy      = r_out_valid | (|req_valid);

endmodule

// File: tb/tb_rr_scope_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a round-robin reference model.
module tb_rr_scope_arbiter;

    localparam int N  = 5;
    localparam int DW = 32;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IW-1:0]   out_idx;
    logic [DW-1:0]   out_data;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] d [N];
    bit            m_valid;
    bit            m_known;
    int            m_idx;
    logic [DW-1:0] m_data;
    int            m_ptr;

    rr_scope_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check grant/busy before the edge, advance model, check slot after.
    task automatic step(input logic [N-1:0] rv, input logic ordy, input logic rst);
        int pick;
        int pos;
        bit free;
        logic [N-1:0] exp_rdy;
        rst_n = rst;
        req_valid = rv;
        out_ready = ordy;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
        #1;
        free = !m_valid || (ordy == 1'b1);
        pick = -1;
        for (int k = 0; k < N; k++) begin
            pos = (m_ptr + k) % N;
            if (pick < 0 && ((rv >> pos) & 5'd1) != 5'd0) pick = pos;
        end
        exp_rdy = '0;
        if (rst && free && pick >= 0) exp_rdy = 5'd1 << pick;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(m_valid | (|rv)));
        @(posedge clk);
        if (!rst) begin
            m_valid = 1'b0; m_idx = 0; m_data = '0; m_ptr = 0; m_known = 1'b1;
        end else if (free && pick >= 0) begin
            m_valid = 1'b1; m_idx = pick; m_data = d[pick];
            m_ptr = (pick + 1) % N; m_known = 1'b1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0; m_known = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_known) begin
            chk("out_idx", 64'(out_idx), 64'(m_idx));
            chk("out_data", 64'(out_data), 64'(m_data));
        end
    endtask

    initial begin
        m_valid = 1'b0; m_known = 1'b0; m_idx = 0; m_data = '0; m_ptr = 0;
        for (int i = 0; i < N; i++) d[i] = DW'(i);

        // Reset then idle
        step(5'b00000, 1'b0, 1'b0);
        step(5'b00000, 1'b0, 1'b0);
        chk("rst_data", 64'(out_data), 64'd0);
        step(5'b00000, 1'b1, 1'b1);
        chk("idle_busy", 64'(busy), 64'd0);

        // Single requester
        d[2] = 32'h2A;
        step(5'b00100, 1'b1, 1'b1);
        chk("single_idx", 64'(out_idx), 64'd2);
        chk("single_data", 64'(out_data), 64'h2A);

        // All valid after reset: 0,1,2,3,4,0 with no bubbles
        d[2] = 32'd2;
        step(5'b11111, 1'b1, 1'b0);
        for (int s = 0; s < 6; s++) begin
            step(5'b11111, 1'b1, 1'b1);
            chk("rr_seq_idx", 64'(out_idx), 64'(s % N));
            chk("rr_seq_valid", 64'(out_valid), 64'd1);
        end

        // Backpressure holding idx 1, then next grant goes to idx 2
        step(5'b00000, 1'b0, 1'b0);
        step(5'b00010, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++) begin
            step(5'b11111, 1'b0, 1'b1);
            chk("bp_idx", 64'(out_idx), 64'd1);
            chk("bp_data", 64'(out_data), 64'd1);
        end
        step(5'b11111, 1'b1, 1'b1);
        chk("bp_release_idx", 64'(out_idx), 64'd2);

        // Wrap from ptr 4
        step(5'b00000, 1'b0, 1'b0);
        step(5'b01000, 1'b1, 1'b1);
        step(5'b00011, 1'b1, 1'b1);
        chk("wrap_idx0", 64'(out_idx), 64'd0);
        step(5'b00011, 1'b1, 1'b1);
        chk("wrap_idx1", 64'(out_idx), 64'd1);

        // Reset while FULL with idx 3
        step(5'b00000, 1'b1, 1'b1);
        step(5'b01000, 1'b0, 1'b1);
        step(5'b00110, 1'b0, 1'b0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        step(5'b00110, 1'b1, 1'b1);
        chk("midrst_first_idx", 64'(out_idx), 64'd1);

        // Random traffic
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < N; i++) d[i] = $urandom;
            step(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_scope_arbiter.md
Name: rr_scope_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one output channel among NUM_REQ generate-replicated requesters.
- Each requester presents an index-tagged data word, e.g. per-instance `x` from a GEN_LOOP block.
- The block sequences the requesters fairly into a single registered output slot with valid/ready handshake.
- Sits between a generate array of per-index producers and a single consumer (trace/display sink or shared bus).

Parameters:
- NUM_REQ, 5, number of requesters (2..16).
- DATA_WIDTH, 32, width of each requester data word.
- IDX_WIDTH, 3, width of the index tag; must satisfy 2**IDX_WIDTH >= NUM_REQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  bit i = requester i has a word.
- req_data  input  NUM_REQ*DATA_WIDTH  word i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  one-hot grant; requester i's word is accepted this cycle when req_valid[i] & req_ready[i].
- out_valid  output  1  output slot holds a word.
- out_ready  input  1  consumer accepts the slot this cycle.
- out_idx  output  IDX_WIDTH  index of the requester whose word is in the slot.
- out_data  output  DATA_WIDTH  the word.
- busy  output  1  out_valid | (|req_valid).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_idx=0, out_data=0.
  - Priority pointer ptr=0; state=EMPTY.
  - req_ready=0 during reset.
- Clock and reset: one clock domain. Reset is synchronous and active-low. A reset mid-transfer drops the slot contents and any pending grant; no partial output.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = (state==EMPTY) | (out_ready & out_valid).
- Grant selection (combinational):
  - Consider req_valid rotated so that ptr is the highest priority.
  - Pick the first set bit at or after ptr, wrapping NUM_REQ-1 -> 0.
  - req_ready is one-hot at the picked index when slot_free, otherwise all-zero.
  - req_ready never depends on out_valid within the same requester's own bit.
- On accept (a grant with req_valid set):
  - At the next edge: out_data <= picked word; out_idx <= picked index; out_valid <= 1; state <= FULL.
  - ptr <= (idx+1) mod NUM_REQ. Wrap uses explicit compare against NUM_REQ-1, not a power-of-two mask.
- Drain without accept: out_valid & out_ready with no req_valid -> state <= EMPTY, out_valid <= 0. ptr is unchanged.
- Simultaneous drain and accept: the slot is reloaded in the same edge. out_valid stays 1, giving one word per cycle.
- Backpressure (FULL and out_ready=0): out_valid, out_idx and out_data are held stable. req_ready=0.
- Latency: accept at cycle N -> out_valid with the data at cycle N+1.
- Fairness: with all requesters valid, grants follow ptr, ptr+1, ... with no requester skipped. Worst-case wait is NUM_REQ grants.
- No request: ptr holds and no state change.

Decomposition:
- Package rr_scope_pkg:
  - state enum {EMPTY, FULL};
  - function idx_inc(idx, n), modulo increment;
  - localparam checks for the IDX_WIDTH/NUM_REQ relation.
- Sub-module rr_pick, purely combinational. Inputs: req vector, ptr. Outputs: one-hot grant, encoded idx, any flag. The top holds the slot register, state and ptr.

Test Plan:
- Reset then idle: rst_n low 2 cycles, then high with req_valid=0 -> out_valid=0, req_ready=0, busy=0, ptr stays 0.
- Single requester: req_valid=5'b00100, req_data[2]=32'h2A, out_ready=1 -> req_ready=5'b00100 in cycle 0. Cycle 1: out_valid=1, out_idx=2, out_data=32'h2A. ptr=3.
- All valid, out_ready=1, data[i]=i -> out_idx sequence 0,1,2,3,4,0 on consecutive cycles with no bubbles.
- Backpressure: slot FULL with idx=1, out_ready=0 for 3 cycles -> out_* stable and req_ready=0. On out_ready=1, next grant goes to idx 2 in the same cycle.
- Wrap: ptr=4, req_valid=5'b00011 -> grant idx 0, then ptr=1, grant idx 1.
- Reset mid-operation: FULL with idx=3, rst_n=0 for one edge -> out_valid=0, ptr=0. First grant after reset goes to the lowest valid index.
